sdram_pattern_tester: RTL
=========================

Name: sdram_pattern_tester

Overview:
- Self-checking traffic generator on the command side of the SDRAM controller. It drives the same cmdTrigger/cmdReady/cmdAddr/cmdWrite/cmdWriteData/cmdReadData/cmdReadDataValid handshake that the UART test top drives today.
- On start it fills an address range with a 16-bit LFSR pattern, then reads the range back with pipelined reads and compares against a regenerated pattern.
- Reports pass/fail, error count and first failing address. Used for board bring-up soak tests without UART interaction.

Parameters:
AddrWidth, 23, width of cmdAddr and range ports
MaxOutstanding, 4, max reads accepted by controller but not yet returned (1..15)
ErrCountWidth, 16, width of errorCount (saturating)

Ports:
clk  in  1  system clock (same clock as SDRAM controller)
rst_  in  1  asynchronous active-low reset
start  in  1  single-cycle request to begin a test; sampled in IDLE or DONE only
addrFirst  in  AddrWidth  first word address (inclusive), latched on start
addrLast  in  AddrWidth  last word address (inclusive), latched on start
seed  in  16  LFSR seed, latched on start; 0 replaced by 16'h0001
busy  out  1  high from cycle after accepted start until DONE
done  out  1  high while in DONE; pass/errorCount/firstErrAddr valid when high
pass  out  1  1 iff errorCount==0 at completion
errorCount  out  ErrCountWidth  mismatching read words, saturates at all-ones
firstErrAddr  out  AddrWidth  address of first mismatch; 0 if none
cmdReady  in  1  controller accepts command this cycle when cmdTrigger also high
cmdTrigger  out  1  command valid
cmdWrite  out  1  1=write, 0=read
cmdAddr  out  AddrWidth  command word address
cmdWriteData  out  16  write data
cmdReadData  in  16  read data
cmdReadDataValid  in  1  one-cycle strobe per completed read, in issue order

Behaviour:
- Reset (rst_ low, asynchronous): state IDLE; all outputs 0; internal counters/LFSRs cleared. Reset mid-test drops cmdTrigger immediately; in-flight controller data after reset release is ignored (IDLE ignores cmdReadDataValid).
- LFSR: Galois, next = v[0] ? (v>>1)^16'hB400 : v>>1. Word k of range (k=0 at addrFirst) = seed advanced k times.
- Address counter is AddrWidth+1 bits; no wrap even when addrLast is all-ones.
- States:
  - IDLE/DONE: on start, latch inputs; clear errorCount, firstErrAddr, pass. If addrLast<addrFirst, go to DONE next cycle with pass=1, no commands. Else go to WRITE.
  - WRITE: cmdTrigger=1, cmdWrite=1, cmdAddr=current, cmdWriteData=write LFSR. A handshake (cmdTrigger&cmdReady at edge) advances address and LFSR; the next command appears the following cycle, giving back-to-back writes. After accepting addrLast, reload address=addrFirst and LFSR=seed, then go to READ.
  - READ: cmdTrigger=1, cmdWrite=0, only while outstanding<MaxOutstanding; otherwise cmdTrigger=0. Outstanding +1 on read accept, -1 on cmdReadDataValid; both in the same cycle leaves it unchanged. After accepting addrLast, go to DRAIN.
  - DRAIN: cmdTrigger=0; wait outstanding==0, then go to DONE.
  - DONE: done=1, busy=0, pass=(errorCount==0). Holds until start or reset.
- Check path (READ/DRAIN): each cmdReadDataValid compares cmdReadData to check LFSR, which advances once per strobe, and tracks a check address. On mismatch: errorCount+1 (saturating); firstErrAddr = check address if errorCount was 0.
- cmdTrigger never deasserts while cmdReady is low once a command is presented, except on reset or the MaxOutstanding gate before presentation. cmdAddr/cmdWrite/cmdWriteData are stable while cmdTrigger&!cmdReady.
- start while busy: ignored. cmdReadDataValid with outstanding==0 outside IDLE: ignored, no error counted.

Optional Feature:
SDRAM_PATTERN_TESTER_INJECT_EN:
- Defined: adds input injectErr (1 bit), latched on start. When latched 1, bit 0 of the first write word is inverted, so a correct memory yields exactly errorCount=1 and firstErrAddr=addrFirst.
- Undefined: port absent; behaviour as if injectErr=0.

Test Plan:
- addrFirst=0x000010, addrLast=0x00001F, seed=0xACE1, ideal SDRAM model, cmdReady always 1 -> 16 back-to-back writes, then 16 reads; done=1, pass=1, errorCount=0; total cycles ≤ 32+read latency+4.
- Same range, model corrupts read of 0x000014 and 0x00001A -> errorCount=2, firstErrAddr=0x000014, pass=0.
- cmdReady toggles randomly, read latency 6 cycles, MaxOutstanding=4 -> outstanding never exceeds 4; cmd fields stable while stalled; pass=1.
- addrFirst=addrLast=0x7FFFFF, seed=0 -> one write of 0x0001, one read, pass=1; no address wrap. Then addrLast<addrFirst -> DONE with no cmdTrigger, pass=1.
- Assert rst_ mid-READ with 3 reads outstanding; stray cmdReadDataValid after release -> all outputs 0, state IDLE, errorCount stays 0.
- With SDRAM_PATTERN_TESTER_INJECT_EN, injectErr=1, range 0x100..0x103 -> errorCount=1, firstErrAddr=0x000100, pass=0.

Source files
------------

// File: rtl/sdram_pattern_tester.sv
// ============================================================================
// Module   : sdram_pattern_tester
// Purpose  : Writes an LFSR pattern over an SDRAM word range through the
//            controller command port, reads it back with pipelined reads and
//            reports pass/fail, the error count and the first failing address.
//            Optional macro SDRAM_PATTERN_TESTER_INJECT_EN adds the injectErr
//            input, which corrupts the first written word.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sdram_pattern_tester #(
  parameter int AddrWidth      = 23,
  parameter int MaxOutstanding = 4,
  parameter int ErrCountWidth  = 16
) (
  input  logic                     clk,
  input  logic                     rst_,
  input  logic                     start,
  input  logic [AddrWidth-1:0]     addrFirst,
  input  logic [AddrWidth-1:0]     addrLast,
  input  logic [15:0]              seed,
`ifdef SDRAM_PATTERN_TESTER_INJECT_EN
  input  logic                     injectErr,
`endif
  output logic                     busy,
  output logic                     done,
  output logic                     pass,
  output logic [ErrCountWidth-1:0] errorCount,
  output logic [AddrWidth-1:0]     firstErrAddr,
  input  logic                     cmdReady,
  output logic                     cmdTrigger,
  output logic                     cmdWrite,
  output logic [AddrWidth-1:0]     cmdAddr,
  output logic [15:0]              cmdWriteData,
  input  logic [15:0]              cmdReadData,
  input  logic                     cmdReadDataValid
);

  localparam logic [15:0] c_poly    = 16'hB400;
  localparam logic [3:0]  c_max_out = 4'(MaxOutstanding);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_WRITE = 3'd1,
    ST_READ  = 3'd2,
    ST_DRAIN = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  function automatic logic [15:0] lfsr_next(input logic [15:0] v);
    return v[0] ? ((v >> 1) ^ c_poly) : (v >> 1);
  endfunction

  state_t                   r_state;
  state_t                   w_next;
  logic [AddrWidth-1:0]     r_first;
  logic [AddrWidth-1:0]     r_last;
  logic [15:0]              r_seed;
  // One extra bit so an all-ones addrLast cannot wrap back into the range
  logic [AddrWidth:0]       r_addr;
  logic [15:0]              r_wlfsr;
  logic [15:0]              r_clfsr;
  logic [AddrWidth-1:0]     r_caddr;
  logic [3:0]               r_outstanding;
  logic [ErrCountWidth-1:0] r_err_count;
  logic [AddrWidth-1:0]     r_first_err;

  logic        w_start_ok;
  logic        w_empty;
  logic        w_trigger;
  logic        w_accept;
  logic        w_at_last;
  logic        w_rd_accept;
  logic        w_rd_strobe;
  logic        w_mismatch;
  logic        w_inj;
  logic [15:0] w_seed;

  assign w_seed      = (seed == 16'h0000) ? 16'h0001 : seed;
  assign w_start_ok  = start && ((r_state == ST_IDLE) || (r_state == ST_DONE));
  assign w_empty     = addrLast < addrFirst;
  assign w_trigger   = (r_state == ST_WRITE) ||
                       ((r_state == ST_READ) && (r_outstanding < c_max_out));
  assign w_accept    = w_trigger && cmdReady;
  assign w_at_last   = (r_addr == {1'b0, r_last});
  assign w_rd_accept = w_accept && (r_state == ST_READ);
  // Strobes outside an active read phase, or with nothing in flight, are stray
  assign w_rd_strobe = cmdReadDataValid && (r_outstanding != 4'd0) &&
                       ((r_state == ST_READ) || (r_state == ST_DRAIN));
  assign w_mismatch  = w_rd_strobe && (cmdReadData != r_clfsr);

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          w_next = w_empty ? ST_DONE : ST_WRITE;
        end
      end
      ST_WRITE: begin
        if (w_accept && w_at_last) begin
          w_next = ST_READ;
        end
      end
      ST_READ: begin
        if (w_accept && w_at_last) begin
          w_next = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (r_outstanding == 4'd0) begin
          w_next = ST_DONE;
        end
      end
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      r_first       <= '0;
      r_last        <= '0;
      r_seed        <= '0;
      r_addr        <= '0;
      r_wlfsr       <= '0;
      r_clfsr       <= '0;
      r_caddr       <= '0;
      r_outstanding <= '0;
      r_err_count   <= '0;
      r_first_err   <= '0;
    end else if (w_start_ok) begin
      r_first       <= addrFirst;
      r_last        <= addrLast;
      r_seed        <= w_seed;
      r_addr        <= {1'b0, addrFirst};
      r_wlfsr       <= w_seed;
      r_clfsr       <= w_seed;
      r_caddr       <= addrFirst;
      r_outstanding <= '0;
      r_err_count   <= '0;
      r_first_err   <= '0;
    end else begin
      if (w_accept) begin
        if (r_state == ST_WRITE) begin
          if (w_at_last) begin
            r_addr  <= {1'b0, r_first};
            r_wlfsr <= r_seed;
          end else begin
            r_addr  <= r_addr + 1'b1;
            r_wlfsr <= lfsr_next(r_wlfsr);
          end
        end else if (!w_at_last) begin
          r_addr <= r_addr + 1'b1;
        end
      end

      case ({w_rd_accept, w_rd_strobe})
        2'b10:   r_outstanding <= r_outstanding + 4'd1;
        2'b01:   r_outstanding <= r_outstanding - 4'd1;
        default: r_outstanding <= r_outstanding;
      endcase

      if (w_rd_strobe) begin
        r_clfsr <= lfsr_next(r_clfsr);
        r_caddr <= r_caddr + 1'b1;
      end

      if (w_mismatch) begin
        if (r_err_count == '0) begin
          r_first_err <= r_caddr;
        end
        if (r_err_count != '1) begin
          r_err_count <= r_err_count + 1'b1;
        end
      end
    end
  end

`ifdef SDRAM_PATTERN_TESTER_INJECT_EN
  logic r_inject;

  // Cleared by the first write handshake so only word 0 is corrupted
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      r_inject <= 1'b0;
    end else if (w_start_ok) begin
      r_inject <= injectErr;
    end else if (w_accept && (r_state == ST_WRITE)) begin
      r_inject <= 1'b0;
    end
  end

  assign w_inj = r_inject;
`else
  assign w_inj = 1'b0;
`endif

  assign busy         = (r_state == ST_WRITE) || (r_state == ST_READ) ||
                        (r_state == ST_DRAIN);
  assign done         = (r_state == ST_DONE);
  assign pass         = (r_state == ST_DONE) && (r_err_count == '0);
  assign errorCount   = r_err_count;
  assign firstErrAddr = r_first_err;
  assign cmdTrigger   = w_trigger;
  assign cmdWrite     = (r_state == ST_WRITE);
  assign cmdAddr      = r_addr[AddrWidth-1:0];
  assign cmdWriteData = (r_state == ST_WRITE) ? (r_wlfsr ^ {15'b0, w_inj}) : 16'h0000;

endmodule

`default_nettype wire
